// File: rtl/l2_mem_pkg.sv
// Shared definitions for the L2 memory-side port arbiter: default widths,
// FSM state encoding and port identifiers.
package l2_mem_pkg;

    localparam int DEF_ADDR_W      = 28;
    localparam int DEF_DATA_W      = 128;
    localparam int DEF_TIMEOUT_CYC = 1024;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        D_BUSY = 2'd1,
        I_BUSY = 2'd2,
        COOL   = 2'd3
    } state_t;

    localparam logic PORT_D = 1'b0;
    localparam logic PORT_I = 1'b1;

    // A side asking for both a read and a write at once is treated as idle.
    function automatic logic req_valid(input logic read, input logic write);
        return read ^ write;
    endfunction

endpackage

// File: rtl/l2_mem_req_latch.sv
// Capture register for the granted request: address, write line and the
// read/write strobes that drive the main-memory port.
module l2_mem_req_latch #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              clear,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              rd_strobe,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] held_addr,
    output logic [DATA_W-1:0] held_wdata
);

    // Address and data stay put after completion; only the strobes drop.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_strobe  <= 1'b0;
            wr_strobe  <= 1'b0;
            held_addr  <= '0;
            held_wdata <= '0;
        end else if (load) begin
            rd_strobe  <= ~write;
            wr_strobe  <= write;
            held_addr  <= addr;
            held_wdata <= wdata;
        end else if (clear) begin
            rd_strobe  <= 1'b0;
            wr_strobe  <= 1'b0;
        end
    end

endmodule

// File: rtl/l2_mem_port_arbiter.sv
// Merges the L2 D-side and I-side memory ports onto one main-memory port,
// one transaction at a time, with round-robin arbitration and a timeout flag.
module l2_mem_port_arbiter
    import l2_mem_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              proc_reset_n,
    input  logic              D_mem_read,
    input  logic              D_mem_write,
    input  logic [ADDR_W-1:0] D_mem_addr,
    input  logic [DATA_W-1:0] D_mem_wdata,
    output logic [DATA_W-1:0] D_mem_rdata,
    output logic              D_mem_ready,
    input  logic              I_mem_read,
    input  logic              I_mem_write,
    input  logic [ADDR_W-1:0] I_mem_addr,
    input  logic [DATA_W-1:0] I_mem_wdata,
    output logic [DATA_W-1:0] I_mem_rdata,
    output logic              I_mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              timeout_err
);

    localparam int               CNT_W       = $clog2(TIMEOUT_CYC + 2);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYC);

    state_t            state;
    logic              last_grant;
    logic [CNT_W-1:0]  wait_cnt;
    logic [DATA_W-1:0] d_hold;
    logic [DATA_W-1:0] i_hold;

    logic              d_valid;
    logic              i_valid;
    logic              grant_d;
    logic              grant_i;
    logic              busy_d;
    logic              busy_i;
    logic              done;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign d_valid = req_valid(D_mem_read, D_mem_write);
    assign i_valid = req_valid(I_mem_read, I_mem_write);
    assign busy_d  = (state == D_BUSY);
    assign busy_i  = (state == I_BUSY);
    assign done    = (busy_d | busy_i) & mem_ready;

    // In COOL, last_grant is the side that just completed; its stale request is ignored.
    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        case (state)
            IDLE: begin
                if (d_valid && (!i_valid || last_grant == PORT_I)) begin
                    grant_d = 1'b1;
                end else if (i_valid) begin
                    grant_i = 1'b1;
                end
            end
            COOL: begin
                if (last_grant == PORT_D) begin
                    grant_i = i_valid;
                end else begin
                    grant_d = d_valid;
                end
            end
            default: ;
        endcase
    end

    assign sel_write = grant_i ? I_mem_write : D_mem_write;
    assign sel_addr  = grant_i ? I_mem_addr  : D_mem_addr;
    assign sel_wdata = grant_i ? I_mem_wdata : D_mem_wdata;

    l2_mem_req_latch #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_req_latch (
        .clk       (clk),
        .reset_n   (proc_reset_n),
        .load      (grant_d | grant_i),
        .clear     (done),
        .write     (sel_write),
        .addr      (sel_addr),
        .wdata     (sel_wdata),
        .rd_strobe (mem_read),
        .wr_strobe (mem_write),
        .held_addr (mem_addr),
        .held_wdata(mem_wdata)
    );

    always_ff @(posedge clk) begin
        if (!proc_reset_n) begin
            state       <= IDLE;
            last_grant  <= PORT_I;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
            d_hold      <= '0;
            i_hold      <= '0;
        end else begin
            case (state)
                IDLE, COOL: begin
                    if (grant_d || grant_i) begin
                        state      <= grant_d ? D_BUSY : I_BUSY;
                        last_grant <= grant_d ? PORT_D : PORT_I;
                        wait_cnt   <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                D_BUSY, I_BUSY: begin
                    if (mem_ready) begin
                        state <= COOL;
                        if (mem_read && busy_d) d_hold <= mem_rdata;
                        if (mem_read && busy_i) i_hold <= mem_rdata;
                    end else begin
                        // Saturates so a long stall cannot wrap and re-trigger.
                        if (wait_cnt < TIMEOUT_CNT) wait_cnt <= wait_cnt + 1'b1;
                        if (TIMEOUT_CYC != 0 && wait_cnt + 1'b1 == TIMEOUT_CNT) timeout_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The L2 samples rdata a cycle after ready, so the held copy must persist.
    assign D_mem_ready = busy_d & mem_ready;
    assign I_mem_ready = busy_i & mem_ready;
    assign D_mem_rdata = (D_mem_ready && mem_read) ? mem_rdata : d_hold;
    assign I_mem_rdata = (I_mem_ready && mem_read) ? mem_rdata : i_hold;

endmodule

// File: tb/tb_l2_mem_port_arbiter.sv
// Self-checking bench for l2_mem_port_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a transaction model.
module tb_l2_mem_port_arbiter;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;
    localparam int TO     = 8;

    logic              clk = 1'b0;
    logic              proc_reset_n;
    logic              D_mem_read, D_mem_write, I_mem_read, I_mem_write;
    logic [ADDR_W-1:0] D_mem_addr, I_mem_addr;
    logic [DATA_W-1:0] D_mem_wdata, I_mem_wdata;
    logic [DATA_W-1:0] D_mem_rdata, I_mem_rdata;
    logic              D_mem_ready, I_mem_ready;
    logic              mem_read, mem_write, mem_ready, timeout_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    l2_mem_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk         (clk),
        .proc_reset_n(proc_reset_n),
        .D_mem_read  (D_mem_read),
        .D_mem_write (D_mem_write),
        .D_mem_addr  (D_mem_addr),
        .D_mem_wdata (D_mem_wdata),
        .D_mem_rdata (D_mem_rdata),
        .D_mem_ready (D_mem_ready),
        .I_mem_read  (I_mem_read),
        .I_mem_write (I_mem_write),
        .I_mem_addr  (I_mem_addr),
        .I_mem_wdata (I_mem_wdata),
        .I_mem_rdata (I_mem_rdata),
        .I_mem_ready (I_mem_ready),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .timeout_err (timeout_err)
    );

    task automatic checkOutput(input string name, input logic [DATA_W-1:0] act,
                               input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: one outstanding transfer, a one-cycle mask on the
    // side that just finished, and preference for the side not granted last.
    bit                m_valid = 1'b0;
    bit                m_busy, m_side, m_write, m_cool, m_cool_side, m_last, m_err;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_hold [2];
    int                m_age;

    always @(negedge clk) begin
        bit done, dv, iv, de, ie, win;
        if (m_valid) begin
            done = m_busy && mem_ready;
            checkOutput("mem_read",    128'(mem_read),    128'(m_busy && !m_write));
            checkOutput("mem_write",   128'(mem_write),   128'(m_busy && m_write));
            checkOutput("mem_addr",    128'(mem_addr),    128'(m_addr));
            checkOutput("mem_wdata",   mem_wdata,         m_wdata);
            checkOutput("D_mem_ready", 128'(D_mem_ready), 128'(done && !m_side));
            checkOutput("I_mem_ready", 128'(I_mem_ready), 128'(done && m_side));
            checkOutput("D_mem_rdata", D_mem_rdata,
                        (done && !m_side && !m_write) ? mem_rdata : m_hold[0]);
            checkOutput("I_mem_rdata", I_mem_rdata,
                        (done && m_side && !m_write) ? mem_rdata : m_hold[1]);
            checkOutput("timeout_err", 128'(timeout_err), 128'(m_err));
        end
        if (!proc_reset_n) begin
            m_valid  = 1'b1;
            m_busy   = 1'b0;
            m_cool   = 1'b0;
            m_last   = 1'b1;
            m_err    = 1'b0;
            m_addr   = '0;
            m_wdata  = '0;
            m_hold[0] = '0;
            m_hold[1] = '0;
            m_age    = 0;
        end else if (m_valid) begin
            dv = D_mem_read ^ D_mem_write;
            iv = I_mem_read ^ I_mem_write;
            if (m_busy) begin
                if (mem_ready) begin
                    if (!m_write) m_hold[m_side] = mem_rdata;
                    m_busy      = 1'b0;
                    m_cool      = 1'b1;
                    m_cool_side = m_side;
                end else begin
                    m_age++;
                    if (m_age >= TO) m_err = 1'b1;
                end
            end else begin
                de = dv && !(m_cool && !m_cool_side);
                ie = iv && !(m_cool && m_cool_side);
                m_cool = 1'b0;
                if (de || ie) begin
                    win     = (de && ie) ? !m_last : ie;
                    m_busy  = 1'b1;
                    m_side  = win;
                    m_last  = win;
                    m_write = win ? I_mem_write : D_mem_write;
                    m_addr  = win ? I_mem_addr  : D_mem_addr;
                    m_wdata = win ? I_mem_wdata : D_mem_wdata;
                    m_age   = 0;
                end
            end
        end
    end

    task automatic resetDut();
        proc_reset_n = 1'b0;
        D_mem_read = 1'b0; D_mem_write = 1'b0;
        I_mem_read = 1'b0; I_mem_write = 1'b0;
        mem_ready  = 1'b0;
        tick();
        tick();
        proc_reset_n = 1'b1;
    endtask

    task automatic testSingleRead();
        logic [DATA_W-1:0] rd;
        int pulses;
        rd = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        pulses = 0;
        D_mem_read = 1'b1;
        D_mem_addr = 28'h0000123;
        tick();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) begin
                checkOutput("A_strobe_latency", 128'(mem_read), 128'(1));
                checkOutput("A_addr", 128'(mem_addr), 128'h123);
            end
            pulses += int'(D_mem_ready);
            tick();
        end
        mem_ready = 1'b1;
        mem_rdata = rd;
        @(negedge clk);
        pulses += int'(D_mem_ready);
        checkOutput("A_rdata_at_ready", D_mem_rdata, rd);
        tick();
        mem_ready  = 1'b0;
        D_mem_read = 1'b0;
        mem_rdata  = rand128();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            pulses += int'(D_mem_ready);
            tick();
        end
        checkOutput("A_ready_pulses", 128'(pulses), 128'(1));
        checkOutput("A_rdata_held", D_mem_rdata, rd);
        checkOutput("A_model_pin", m_hold[0], rd);
    endtask

    task automatic testBothReads();
        logic [DATA_W-1:0] rd1, rd2;
        rd1 = 128'h1111_0000_0000_0000_0000_0000_0000_0001;
        rd2 = 128'h2222_0000_0000_0000_0000_0000_0000_0002;
        resetDut();
        D_mem_read = 1'b1; D_mem_addr = 28'h0ABCDE0;
        I_mem_read = 1'b1; I_mem_addr = 28'h0123450;
        tick();
        @(negedge clk);
        checkOutput("B_first_addr", 128'(mem_addr), 128'h0ABCDE0);
        tick();
        mem_ready = 1'b1;
        mem_rdata = rd1;
        @(negedge clk);
        checkOutput("B_d_ready", 128'(D_mem_ready), 128'(1));
        checkOutput("B_i_not_ready", 128'(I_mem_ready), 128'(0));
        tick();
        mem_ready  = 1'b0;
        D_mem_read = 1'b0;
        @(negedge clk);
        checkOutput("B_cool_strobe", 128'(mem_read), 128'(0));
        tick();
        mem_ready = 1'b1;
        mem_rdata = rd2;
        @(negedge clk);
        checkOutput("B_i_strobe_no_idle", 128'(mem_read), 128'(1));
        checkOutput("B_i_addr", 128'(mem_addr), 128'h0123450);
        checkOutput("B_i_ready", 128'(I_mem_ready), 128'(1));
        checkOutput("B_d_quiet", 128'(D_mem_ready), 128'(0));
        tick();
        mem_ready  = 1'b0;
        I_mem_read = 1'b0;
        @(negedge clk);
        checkOutput("B_d_rdata_held", D_mem_rdata, rd1);
        checkOutput("B_i_rdata_held", I_mem_rdata, rd2);
        tick();
    endtask

    task automatic testStaleMasked();
        D_mem_read = 1'b1;
        D_mem_addr = 28'h0000456;
        tick();
        mem_ready = 1'b1;
        mem_rdata = rand128();
        @(negedge clk);
        checkOutput("C_ready", 128'(D_mem_ready), 128'(1));
        tick();
        mem_ready = 1'b0;
        @(negedge clk);
        checkOutput("C_cool_strobe", 128'(mem_read), 128'(0));
        tick();
        D_mem_read = 1'b0;
        @(negedge clk);
        checkOutput("C_no_reissue", 128'(mem_read), 128'(0));
        tick();
        @(negedge clk);
        checkOutput("C_still_idle", 128'(mem_read), 128'(0));
        tick();
    endtask

    task automatic testWriteHold();
        logic [DATA_W-1:0] wd;
        wd = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
        D_mem_write = 1'b1;
        D_mem_addr  = 28'h0A00010;
        D_mem_wdata = wd;
        tick();
        for (int k = 0; k < 3; k++) begin
            D_mem_addr  = 28'($urandom);
            D_mem_wdata = rand128();
            @(negedge clk);
            checkOutput("D_write_strobe", 128'(mem_write), 128'(1));
            checkOutput("D_read_quiet", 128'(mem_read), 128'(0));
            checkOutput("D_addr_stable", 128'(mem_addr), 128'h0A00010);
            checkOutput("D_wdata_stable", mem_wdata, wd);
            tick();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        checkOutput("D_write_ready", 128'(D_mem_ready), 128'(1));
        tick();
        mem_ready   = 1'b0;
        D_mem_write = 1'b0;
        @(negedge clk);
        checkOutput("D_write_done", 128'(mem_write), 128'(0));
        tick();
    endtask

    task automatic testTimeout();
        I_mem_read = 1'b1;
        I_mem_addr = 28'h0000777;
        tick();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checkOutput("E_timeout_err", 128'(timeout_err), 128'(k >= 8));
            checkOutput("E_strobe_held", 128'(mem_read), 128'(1));
            tick();
        end
        mem_ready = 1'b1;
        mem_rdata = 128'h5A5A;
        @(negedge clk);
        checkOutput("E_late_ready", 128'(I_mem_ready), 128'(1));
        tick();
        mem_ready  = 1'b0;
        I_mem_read = 1'b0;
        @(negedge clk);
        checkOutput("E_err_sticky", 128'(timeout_err), 128'(1));
        checkOutput("E_strobe_drop", 128'(mem_read), 128'(0));
        checkOutput("E_model_pin", 128'(m_err), 128'(1));
        tick();
    endtask

    task automatic testResetBusy();
        I_mem_read = 1'b1;
        I_mem_addr = 28'h0000888;
        tick();
        tick();
        proc_reset_n = 1'b0;
        tick();
        mem_ready = 1'b1;
        mem_rdata = rand128();
        @(negedge clk);
        checkOutput("F_read_drop", 128'(mem_read), 128'(0));
        checkOutput("F_write_drop", 128'(mem_write), 128'(0));
        checkOutput("F_no_ready", 128'(I_mem_ready), 128'(0));
        checkOutput("F_err_clear", 128'(timeout_err), 128'(0));
        checkOutput("F_rdata_clear", I_mem_rdata, 128'(0));
        tick();
        mem_ready    = 1'b0;
        I_mem_read   = 1'b0;
        proc_reset_n = 1'b1;
        tick();
    endtask

    int d_st, i_st, mem_lat;
    bit mem_pending;

    // A requester holds its request until ready, then sometimes leaves it up one more cycle.
    task automatic driveSide(input bit done, input int wr_odds, inout int st,
                             inout logic rd, inout logic wr,
                             inout logic [ADDR_W-1:0] a, inout logic [DATA_W-1:0] wd);
        int n;
        case (st)
            1: begin
                if (done) begin
                    if ($urandom_range(0, 1) == 1) st = 2;
                    else begin st = 0; rd = 1'b0; wr = 1'b0; end
                end else if ($urandom_range(0, 3) == 0) begin
                    a  = ADDR_W'($urandom);
                    wd = rand128();
                end
            end
            2: begin st = 0; rd = 1'b0; wr = 1'b0; end
            default: begin
                rd = 1'b0;
                wr = 1'b0;
                n  = int'($urandom_range(0, 15));
                if (n < 4) begin
                    st = 1;
                    wr = ($urandom_range(0, wr_odds - 1) == 0);
                    rd = !wr;
                    a  = ADDR_W'($urandom);
                    wd = rand128();
                end else if (n == 4) begin
                    rd = 1'b1;
                    wr = 1'b1;
                end
            end
        endcase
    endtask

    task automatic applyStimulus();
        bit d_done, i_done;
        @(negedge clk);
        d_done = D_mem_ready;
        i_done = I_mem_ready;
        tick();
        mem_rdata = rand128();
        if (mem_ready) begin
            mem_ready = 1'b0;
        end else if (mem_read || mem_write) begin
            if (!mem_pending) begin
                mem_pending = 1'b1;
                mem_lat = ($urandom_range(0, 31) == 0) ? int'($urandom_range(9, 12))
                                                       : int'($urandom_range(0, 5));
            end
            if (mem_lat == 0) begin
                mem_ready   = 1'b1;
                mem_pending = 1'b0;
            end else begin
                mem_lat--;
            end
        end else begin
            mem_ready = ($urandom_range(0, 15) == 0);
        end
        driveSide(d_done, 4, d_st, D_mem_read, D_mem_write, D_mem_addr, D_mem_wdata);
        driveSide(i_done, 8, i_st, I_mem_read, I_mem_write, I_mem_addr, I_mem_wdata);
    endtask

    initial begin
        proc_reset_n = 1'b0;
        D_mem_read = 1'b0; D_mem_write = 1'b0; D_mem_addr = '0; D_mem_wdata = '0;
        I_mem_read = 1'b0; I_mem_write = 1'b0; I_mem_addr = '0; I_mem_wdata = '0;
        mem_ready  = 1'b0; mem_rdata = '0;
        tick();
        tick();
        proc_reset_n = 1'b1;
        @(negedge clk);
        checkOutput("R_mem_read", 128'(mem_read), 128'(0));
        checkOutput("R_mem_write", 128'(mem_write), 128'(0));
        checkOutput("R_mem_addr", 128'(mem_addr), 128'(0));
        checkOutput("R_D_rdata", D_mem_rdata, 128'(0));
        checkOutput("R_I_rdata", I_mem_rdata, 128'(0));
        checkOutput("R_timeout_err", 128'(timeout_err), 128'(0));
        tick();

        testSingleRead();
        testBothReads();
        testStaleMasked();
        testWriteHold();
        testTimeout();
        testResetBusy();

        d_st = 0;
        i_st = 0;
        mem_pending = 1'b0;
        mem_lat = 0;
        repeat (1500) applyStimulus();

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
